// File: rtl/dbus_responder.sv
// Data-bus responder for the cpu32 core: word-addressed scratch RAM, console TX FIFO
// and a free-running cycle counter, all served with zero wait states.
module dbus_responder #(
   parameter int RAM_AW  = 10,
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_data_w,
   input  logic        d_we,
   output logic [31:0] d_data_r,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int RAM_DEPTH  = 1 << RAM_AW;
   localparam int FIFO_DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT    = (FIFO_AW + 1)'(FIFO_DEPTH);
   localparam logic [3:0]       REGION_RAM  = 4'h0;
   localparam logic [3:0]       REGION_MMIO = 4'hF;
   localparam logic [1:0]       REG_TX      = 2'd0;
   localparam logic [1:0]       REG_STATUS  = 2'd1;
   localparam logic [1:0]       REG_CYCLES  = 2'd2;

   logic [31:0]        ram_q [RAM_DEPTH];
   logic [7:0]         fifo_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic [31:0]        cycles_q, cycles_d;

   logic               sel_ram_s, sel_mmio_s;
   logic [1:0]         reg_sel_s;
   logic [RAM_AW-1:0]  ram_idx_s;
   logic               full_s, empty_s, push_s, pop_s, tx_wr_s;
   logic               ovf_set_s, ovf_clr_s, cyc_wr_s, ram_we_s;
   logic [31:0]        status_s, rdata_s;
   logic               unused_addr_s;

   assign unused_addr_s = ^{d_addr[27:RAM_AW+2], d_addr[1:0]};

   // Address decode and FIFO handshake qualifiers, all from pre-edge state.
   always_comb begin
      sel_ram_s  = (d_addr[31:28] == REGION_RAM);
      sel_mmio_s = (d_addr[31:28] == REGION_MMIO);
      reg_sel_s  = d_addr[3:2];
      ram_idx_s  = d_addr[RAM_AW+1:2];
      full_s     = (count_q == FULL_CNT);
      empty_s    = (count_q == '0);
      ram_we_s   = d_we && sel_ram_s;
      tx_wr_s    = d_we && sel_mmio_s && (reg_sel_s == REG_TX);
      cyc_wr_s   = d_we && sel_mmio_s && (reg_sel_s == REG_CYCLES);
      ovf_clr_s  = d_we && sel_mmio_s && (reg_sel_s == REG_STATUS) && d_data_w[2];
      push_s     = tx_wr_s && !full_s;
      ovf_set_s  = tx_wr_s && full_s;
      pop_s      = !empty_s && tx_ready;
   end

   // Next-state for FIFO pointers, count, overflow flag and cycle counter.
   always_comb begin
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
         2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
         default: count_d = count_q;
      endcase
      // A dropped push beats a clear, should both ever coincide.
      if (ovf_set_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      // A loaded value has already counted its own cycle when first read back.
      if (cyc_wr_s) begin
         cycles_d = d_data_w + 32'd1;
      end else begin
         cycles_d = cycles_q + 32'd1;
      end
   end

   // Load data mux; reads never change state.
   always_comb begin
      status_s                = 32'd0;
      status_s[0]             = full_s;
      status_s[1]             = empty_s;
      status_s[2]             = ovf_q;
      status_s[FIFO_AW+8:8]   = count_q;
      rdata_s                 = 32'd0;
      case (d_addr[31:28])
         REGION_RAM:  rdata_s = ram_q[ram_idx_s];
         REGION_MMIO: begin
            case (reg_sel_s)
               REG_STATUS: rdata_s = status_s;
               REG_CYCLES: rdata_s = cycles_q;
               default:    rdata_s = 32'd0;
            endcase
         end
         default:     rdata_s = 32'd0;
      endcase
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         cycles_q <= 32'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         cycles_q <= cycles_d;
      end
   end

   // Storage arrays are deliberately not reset.
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         ram_q[ram_idx_s] <= d_data_w;
      end
      if (push_s) begin
         fifo_q[wr_ptr_q] <= d_data_w[7:0];
      end
   end

   assign d_data_r = rdata_s;
   assign tx_data  = fifo_q[rd_ptr_q];
   assign tx_valid = !empty_s;

endmodule
